// File: rtl/decode_stage_hs_if.sv
// Handshake bundle between fetch, writeback, execute and the decode stage.
// The decode stage takes the slave view; whatever drives it takes the master view.
interface decode_stage_hs_if #(
    parameter int ADDRESS_WIDTH     = 64,
    parameter int REGISTER_WIDTH    = 64,
    parameter int REGISTERNO_WIDTH  = 5,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int STALL_CNT_WIDTH   = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic [ADDRESS_WIDTH-1:0]     in_pc;
    logic [INSTRUCTION_WIDTH-1:0] in_instruction;
    logic                         in_wb_enable;
    logic [REGISTERNO_WIDTH-1:0]  in_wb_regno;
    logic [REGISTER_WIDTH-1:0]    in_wb_value;
    logic                         in_flush;
    logic                         in_ex_is_load;
    logic [REGISTERNO_WIDTH-1:0]  in_ex_rd_regno;
    logic                         in_ex_ready;
    logic                         out_valid;
    logic [ADDRESS_WIDTH-1:0]     out_pc;
    logic [INSTRUCTION_WIDTH-1:0] out_instruction;
    logic [REGISTER_WIDTH-1:0]    out_rs1_value;
    logic [REGISTER_WIDTH-1:0]    out_rs2_value;
    logic [REGISTER_WIDTH-1:0]    out_imm_value;
    logic [REGISTERNO_WIDTH-1:0]  out_rs1_regno;
    logic [REGISTERNO_WIDTH-1:0]  out_rs2_regno;
    logic [REGISTERNO_WIDTH-1:0]  out_rd_regno;
    logic [STALL_CNT_WIDTH-1:0]   out_stall_count;

    modport master (
        output in_valid, in_pc, in_instruction, in_wb_enable, in_wb_regno, in_wb_value,
               in_flush, in_ex_is_load, in_ex_rd_regno, in_ex_ready,
        input  in_ready, out_valid, out_pc, out_instruction, out_rs1_value, out_rs2_value,
               out_imm_value, out_rs1_regno, out_rs2_regno, out_rd_regno, out_stall_count
    );

    modport slave (
        input  in_valid, in_pc, in_instruction, in_wb_enable, in_wb_regno, in_wb_value,
               in_flush, in_ex_is_load, in_ex_rd_regno, in_ex_ready,
        output in_ready, out_valid, out_pc, out_instruction, out_rs1_value, out_rs2_value,
               out_imm_value, out_rs1_regno, out_rs2_regno, out_rd_regno, out_stall_count
    );
endinterface

// File: rtl/decode_stage_hs.sv
// RV64I decode stage: register file with WB bypass, load-use bubble insertion,
// branch flush and a saturating stall counter, valid/ready on both sides.
module decode_stage_hs #(
    parameter int ADDRESS_WIDTH     = 64,
    parameter int REGISTER_WIDTH    = 64,
    parameter int NUM_REGS          = 32,
    parameter int REGISTERNO_WIDTH  = $clog2(NUM_REGS),
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int STALL_CNT_WIDTH   = 16
) (
    input logic              clk,
    input logic              reset,
    decode_stage_hs_if.slave bus
);

    typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic                         valid;
        logic [ADDRESS_WIDTH-1:0]     pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
        logic [REGISTER_WIDTH-1:0]    rs1_value;
        logic [REGISTER_WIDTH-1:0]    rs2_value;
        logic [REGISTER_WIDTH-1:0]    imm_value;
        logic [REGISTERNO_WIDTH-1:0]  rs1_regno;
        logic [REGISTERNO_WIDTH-1:0]  rs2_regno;
        logic [REGISTERNO_WIDTH-1:0]  rd_regno;
    } slot_t;

    slot_t                      slot_q, slot_d, decoded;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [REGISTER_WIDTH-1:0]  regfile_q [NUM_REGS];
    logic [REGISTER_WIDTH-1:0]  regfile_d [NUM_REGS];

    fmt_e                        fmt;
    logic [INSTRUCTION_WIDTH-1:0] ins;
    logic [31:0]                 imm32;
    logic [REGISTERNO_WIDTH-1:0] rs1, rs2;
    logic                        use_rs1, use_rs2, hazard, free;

    assign ins = bus.in_instruction;
    assign rs1 = REGISTERNO_WIDTH'(ins[19:15]);
    assign rs2 = REGISTERNO_WIDTH'(ins[24:20]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fmt   = FMT_NONE;
        imm32 = '0;
        unique case (ins[6:0])
            7'b0110011, 7'b0111011:                                  fmt = FMT_R;
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0100011:                                              fmt = FMT_S;
            7'b1100011:                                              fmt = FMT_B;
            7'b0110111, 7'b0010111:                                  fmt = FMT_U;
            7'b1101111:                                              fmt = FMT_J;
            default:                                                 fmt = FMT_NONE;
        endcase
        case (fmt)
            FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm32 = {ins[31:12], 12'b0};
            FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign use_rs1 = (fmt != FMT_U) && (fmt != FMT_J);
    assign use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

    assign hazard = bus.in_valid && bus.in_ex_is_load && (bus.in_ex_rd_regno != '0) &&
                    ((use_rs1 && rs1 == bus.in_ex_rd_regno) ||
                     (use_rs2 && rs2 == bus.in_ex_rd_regno));
    assign free     = !slot_q.valid || bus.in_ex_ready;
    assign bus.in_ready = !reset && !bus.in_flush && !hazard && free;

    // Operand read: x0 is always zero, a same-cycle writeback wins over the stored value.
    always_comb begin
        decoded             = '0;
        decoded.valid       = 1'b1;
        decoded.pc          = bus.in_pc;
        decoded.instruction = ins;
        decoded.imm_value   = {{(REGISTER_WIDTH-32){imm32[31]}}, imm32};
        decoded.rs1_regno   = rs1;
        decoded.rs2_regno   = rs2;
        decoded.rd_regno    = REGISTERNO_WIDTH'(ins[11:7]);
        if (rs1 != '0)
            decoded.rs1_value = (bus.in_wb_enable && bus.in_wb_regno == rs1) ? bus.in_wb_value
                                                                           : regfile_q[rs1];
        if (rs2 != '0)
            decoded.rs2_value = (bus.in_wb_enable && bus.in_wb_regno == rs2) ? bus.in_wb_value
                                                                           : regfile_q[rs2];
    end

    always_comb begin
        regfile_d = regfile_q;
        if (bus.in_wb_enable && bus.in_wb_regno != '0)
            regfile_d[bus.in_wb_regno] = bus.in_wb_value;
    end

    always_comb begin
        // A held instruction keeps its operands current with writebacks that land while it waits.
        slot_d      = slot_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.in_wb_enable && bus.in_wb_regno != '0) begin
            if (bus.in_wb_regno == slot_q.rs1_regno) slot_d.rs1_value = bus.in_wb_value;
            if (bus.in_wb_regno == slot_q.rs2_regno) slot_d.rs2_value = bus.in_wb_value;
        end
        if (bus.in_flush) begin
            slot_d.valid = 1'b0;
        end else if (hazard) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
            if (free) slot_d.valid = 1'b0;
        end else if (free) begin
            if (bus.in_valid) slot_d = decoded;
            else              slot_d.valid = 1'b0;
        end
    end

    // NOTE: sequential state is only ever written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            stall_cnt_q <= '0;
            // NOTE: the register file is deliberately cleared on reset; this forces flops, not RAM.
            regfile_q   <= '{default: '0};
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
            regfile_q   <= regfile_d;
        end
    end

    assign bus.out_valid       = slot_q.valid;
    assign bus.out_pc          = slot_q.pc;
    assign bus.out_instruction = slot_q.instruction;
    assign bus.out_rs1_value   = slot_q.rs1_value;
    assign bus.out_rs2_value   = slot_q.rs2_value;
    assign bus.out_imm_value   = slot_q.imm_value;
    assign bus.out_rs1_regno   = slot_q.rs1_regno;
    assign bus.out_rs2_regno   = slot_q.rs2_regno;
    assign bus.out_rd_regno    = slot_q.rd_regno;
    assign bus.out_stall_count = stall_cnt_q;

endmodule
